// File: rtl/spi_mux_n.sv
// spi_mux_n: SPI mode-3 (CPOL=1, CPHA=1) multiplexer routing one upstream
// slave interface to one of NPORTS downstream devices. The first byte of a
// transaction is the port address; GAP_BYTES turnaround bytes follow, then
// the selected port is connected combinationally for the rest of the
// transaction. MISO carries MUX_ID during the address byte and an echo of
// the address (or 8'hFF if invalid) during each turnaround byte.
// Optional feature macro: SPI_MUX_BCAST_EN (address 8'hFF selects all ports,
// MISO becomes the AND of every port's MISO).
// Clocked by s_sclk on both edges; s_ss high is an asynchronous reset.
module spi_mux_n #(
  parameter int unsigned NPORTS    = 4,
  parameter int unsigned GAP_BYTES = 1,
  parameter logic [7:0]  MUX_ID    = 8'hA5
) (
  input  logic              s_sclk,
  input  logic              s_ss,
  input  logic              s_mosi,
  output logic              s_miso,
  output logic [0:NPORTS-1] m_ss,
  output logic [0:NPORTS-1] m_sclk,
  output logic [0:NPORTS-1] m_mosi,
  input  logic [0:NPORTS-1] m_miso
);

  localparam int unsigned HDR_LEN = 8 * (1 + GAP_BYTES);
  localparam int unsigned CNT_W   = $clog2(HDR_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_GAP_LAST  = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_PASS      = CNT_W'(HDR_LEN);

  typedef enum logic [1:0] {
    HDR_ADDR,
    HDR_GAP,
    PASS
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [7:0]        addr_q, addr_d;
  logic              miso_q, miso_d;

  logic [7:0]        echo;
  logic [0:NPORTS-1] sel;
  logic              pass_miso;

  // Header sequencing: rising-edge count, address shift/capture, state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;

    // Counter saturates at HDR_LEN so arbitrarily long transfers never wrap.
    if (cnt_q != CNT_PASS) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      HDR_ADDR: begin
        if (cnt_q == CNT_ADDR_LAST) begin
          addr_d  = {shift_q, s_mosi};
          state_d = HDR_GAP;
        end else begin
          shift_d = {shift_q[5:0], s_mosi};
        end
      end
      HDR_GAP: begin
        if (cnt_q == CNT_GAP_LAST) begin
          state_d = PASS;
        end
      end
      default: ;
    endcase
  end

  // Header state registers, advanced on upstream rising edges.
  always_ff @(posedge s_sclk or posedge s_ss) begin
    if (s_ss) begin
      state_q <= HDR_ADDR;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
    end
  end

  // Echo byte and header MISO bit for the upcoming rising edge.
  always_comb begin
    // Address 0 and 1..NPORTS echo back verbatim; everything else reads 8'hFF
    // (which also covers the broadcast address when enabled).
    echo = (32'(addr_q) <= NPORTS) ? addr_q : 8'hFF;
    case (state_q)
      HDR_ADDR: miso_d = MUX_ID[~cnt_q[2:0]];
      HDR_GAP:  miso_d = echo[~cnt_q[2:0]];
      default:  miso_d = 1'b0;
    endcase
  end

  // Header MISO changes only on falling edges (setup for the next rising edge).
  always_ff @(negedge s_sclk or posedge s_ss) begin
    if (s_ss) begin
      miso_q <= 1'b0;
    end else begin
      miso_q <= miso_d;
    end
  end

  // Port decode in PASS and pass-through MISO selection.
  always_comb begin
    sel       = '0;
    pass_miso = 1'b0;
    if (state_q == PASS) begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (addr_q == 8'(i + 1)) begin
          sel[i]    = 1'b1;
          pass_miso = m_miso[i];
        end
      end
`ifdef SPI_MUX_BCAST_EN
      if (addr_q == 8'hFF) begin
        sel       = '1;
        pass_miso = &m_miso;
      end
`endif
    end
  end

  // Downstream drive: selected ports follow upstream select/clock, idle ports
  // are held deselected with clock high. Selection only changes while s_sclk
  // is high (after a rising edge) or on reset, so m_sclk cannot glitch.
  always_comb begin
    for (int unsigned i = 0; i < NPORTS; i++) begin
      m_ss[i]   = sel[i] ? s_ss   : 1'b1;
      m_sclk[i] = sel[i] ? s_sclk : 1'b1;
    end
    m_mosi = {NPORTS{s_mosi}};
    s_miso = s_ss ? 1'b0 : ((state_q == PASS) ? pass_miso : miso_q);
  end

endmodule

// File: tb/tb_spi_mux_n.sv
// Self-checking bench for spi_mux_n. Two instances: default parameters and
// GAP_BYTES=3. A mode-3 master drives bytes; the expected MISO byte is pushed
// to a scoreboard queue when each byte is started and popped when the byte
// has been shifted in. Per-port select/clock activity is counted per byte.
module tb_spi_mux_n;

  localparam int NP = 4;

`ifdef SPI_MUX_BCAST_EN
  localparam logic [0:NP-1] BSEL = 4'b1111;
`else
  localparam logic [0:NP-1] BSEL = 4'b0000;
`endif

  logic s_sclk = 1'b1;
  logic s_mosi = 1'b0;
  logic ss1    = 1'b1;
  logic ss3    = 1'b1;
  logic s_miso1, s_miso3;
  logic [0:NP-1] m_ss1, m_sclk1, m_mosi1;
  logic [0:NP-1] m_ss3, m_sclk3, m_mosi3;
  logic [0:NP-1] m_miso = '0;

  spi_mux_n u_dut (
    .s_sclk (s_sclk),
    .s_ss   (ss1),
    .s_mosi (s_mosi),
    .s_miso (s_miso1),
    .m_ss   (m_ss1),
    .m_sclk (m_sclk1),
    .m_mosi (m_mosi1),
    .m_miso (m_miso)
  );

  spi_mux_n #(.NPORTS(NP), .GAP_BYTES(3), .MUX_ID(8'hA5)) u_dut3 (
    .s_sclk (s_sclk),
    .s_ss   (ss3),
    .s_mosi (s_mosi),
    .s_miso (s_miso3),
    .m_ss   (m_ss3),
    .m_sclk (m_sclk3),
    .m_mosi (m_mosi3),
    .m_miso (m_miso)
  );

  int         n_vec = 0;
  int         n_err = 0;
  bit         dsel  = 1'b0;
  logic [7:0] sb_q[$];
  logic [7:0] miso_pat [NP];
  int         ss_lo_cnt   [NP];
  int         ss_hi_cnt   [NP];
  int         sclk_lo_cnt [NP];
  int         glitch_cnt;
  int         mosi_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One mode-3 bit: falling edge sets up data, sample mid-low, rising edge,
  // sample mid-high.
  task automatic spi_bit(input logic b, input int bi, output logic rx);
    logic [0:NP-1] mss, msc, mmo;
    s_sclk = 1'b0;
    s_mosi = b;
    for (int p = 0; p < NP; p++) m_miso[p] = miso_pat[p][7-bi];
    #5;
    rx  = dsel ? s_miso3 : s_miso1;
    mss = dsel ? m_ss3   : m_ss1;
    msc = dsel ? m_sclk3 : m_sclk1;
    mmo = dsel ? m_mosi3 : m_mosi1;
    for (int p = 0; p < NP; p++) begin
      if (mss[p] === 1'b0) ss_lo_cnt[p]++;
      if (msc[p] === 1'b0) sclk_lo_cnt[p]++;
    end
    if (mmo !== {NP{b}}) mosi_bad++;
    #5;
    s_sclk = 1'b1;
    #5;
    mss = dsel ? m_ss3   : m_ss1;
    msc = dsel ? m_sclk3 : m_sclk1;
    for (int p = 0; p < NP; p++) begin
      if (mss[p] === 1'b0) ss_hi_cnt[p]++;
      if (msc[p] !== 1'b1) glitch_cnt++;
    end
    #5;
  endtask

  // sel: ports selected for the whole byte; enter: ports whose select falls
  // at this byte's last rising edge.
  task automatic xfer_byte(input logic [7:0] tx, input logic [0:NP-1] sel,
                           input logic [0:NP-1] enter, input string tag);
    logic [7:0] rx, exp;
    logic r;
    for (int p = 0; p < NP; p++) begin
      ss_lo_cnt[p] = 0; ss_hi_cnt[p] = 0; sclk_lo_cnt[p] = 0;
    end
    glitch_cnt = 0;
    mosi_bad   = 0;
    rx = '0;
    for (int bi = 0; bi < 8; bi++) begin
      spi_bit(tx[7-bi], bi, r);
      rx = {rx[6:0], r};
    end
    exp = sb_q.pop_front();
    check({tag, "/miso"}, 32'(rx), 32'(exp));
    for (int p = 0; p < NP; p++) begin
      check($sformatf("%s/ss_lo%0d", tag, p), ss_lo_cnt[p], sel[p] ? 8 : 0);
      check($sformatf("%s/ss_hi%0d", tag, p), ss_hi_cnt[p], sel[p] ? 8 : (enter[p] ? 1 : 0));
      check($sformatf("%s/sclk%0d", tag, p), sclk_lo_cnt[p], sel[p] ? 8 : 0);
    end
    check({tag, "/glitch_mosi"}, glitch_cnt + mosi_bad, 0);
  endtask

  task automatic send(input logic [7:0] tx, input logic [7:0] exp,
                      input logic [0:NP-1] sel, input logic [0:NP-1] enter,
                      input string tag);
    sb_q.push_back(exp);
    xfer_byte(tx, sel, enter, tag);
  endtask

  task automatic txn_start();
    if (dsel) ss3 = 1'b0; else ss1 = 1'b0;
    #10;
  endtask

  // Deselect and confirm everything returns to the idle state at once.
  task automatic txn_end(input string tag);
    if (dsel) ss3 = 1'b1; else ss1 = 1'b1;
    #2;
    if (dsel) check({tag, "/idle"}, 32'({s_miso3, m_ss3, m_sclk3}), 32'h0FF);
    else      check({tag, "/idle"}, 32'({s_miso1, m_ss1, m_sclk1}), 32'h0FF);
    #8;
  endtask

  initial begin
    logic r;
    logic [7:0] partial;

    for (int p = 0; p < NP; p++) miso_pat[p] = 8'h00;

    // Reset state with select high, MISO lines driven high.
    m_miso = '1;
    #3;
    check("rst/dut1", 32'({s_miso1, m_ss1, m_sclk1}), 32'h0FF);
    check("rst/dut3", 32'({s_miso3, m_ss3, m_sclk3}), 32'h0FF);
    check("rst/mosi0", 32'({m_mosi1, m_mosi3}), 32'h00);
    s_mosi = 1'b1;
    #2;
    check("rst/mosi1", 32'({m_mosi1, m_mosi3}), 32'hFF);
    #5;

    // Port 1 (address 2), two pass-through bytes; second checks saturation.
    dsel = 1'b0;
    miso_pat[0] = 8'hFF; miso_pat[2] = 8'hFF; miso_pat[3] = 8'hFF;
    miso_pat[1] = 8'h00;
    txn_start();
    send(8'h02, 8'hA5, 4'b0000, 4'b0000, "p1/b1");
    send(8'h00, 8'h02, 4'b0000, 4'b0100, "p1/b2");
    miso_pat[1] = 8'h5A;
    send(8'hC3, 8'h5A, 4'b0100, 4'b0000, "p1/b3");
    miso_pat[1] = 8'h96;
    send(8'h3C, 8'h96, 4'b0100, 4'b0000, "p1/b4");
    txn_end("p1");

    // Invalid address 7: echo FF, nothing selected, MISO 0.
    for (int p = 0; p < NP; p++) miso_pat[p] = 8'hFF;
    txn_start();
    send(8'h07, 8'hA5, 4'b0000, 4'b0000, "a7/b1");
    send(8'h00, 8'hFF, 4'b0000, 4'b0000, "a7/b2");
    send(8'h55, 8'h00, 4'b0000, 4'b0000, "a7/b3");
    txn_end("a7");

    // Address 0: echo 00, nothing selected.
    txn_start();
    send(8'h00, 8'hA5, 4'b0000, 4'b0000, "a0/b1");
    send(8'hAA, 8'h00, 4'b0000, 4'b0000, "a0/b2");
    send(8'h0F, 8'h00, 4'b0000, 4'b0000, "a0/b3");
    txn_end("a0");

    // Abort after 5 address bits of 8'h01, then address 3 selects port 2.
    partial = 8'h01;
    txn_start();
    for (int bi = 0; bi < 5; bi++) spi_bit(partial[7-bi], bi, r);
    txn_end("abort");
    for (int p = 0; p < NP; p++) miso_pat[p] = 8'hFF;
    miso_pat[2] = 8'h69;
    txn_start();
    send(8'h03, 8'hA5, 4'b0000, 4'b0000, "a3/b1");
    send(8'h00, 8'h03, 4'b0000, 4'b0010, "a3/b2");
    send(8'hE7, 8'h69, 4'b0010, 4'b0000, "a3/b3");
    txn_end("a3");

    // Broadcast address with m_miso = {1,0,1,1}.
    miso_pat[0] = 8'hFF; miso_pat[1] = 8'h00; miso_pat[2] = 8'hFF; miso_pat[3] = 8'hFF;
    txn_start();
    send(8'hFF, 8'hA5, 4'b0000, 4'b0000, "bc/b1");
    send(8'h00, 8'hFF, 4'b0000, BSEL,    "bc/b2");
    send(8'h81, 8'h00, BSEL,    4'b0000, "bc/b3");
    txn_end("bc");

    // GAP_BYTES=3 instance, address 4: echo three times, port 3 at edge 32.
    dsel = 1'b1;
    for (int p = 0; p < NP; p++) miso_pat[p] = 8'h00;
    txn_start();
    send(8'h04, 8'hA5, 4'b0000, 4'b0000, "g3/b1");
    send(8'h00, 8'h04, 4'b0000, 4'b0000, "g3/b2");
    send(8'h00, 8'h04, 4'b0000, 4'b0000, "g3/b3");
    send(8'h00, 8'h04, 4'b0000, 4'b0001, "g3/b4");
    miso_pat[3] = 8'h3C;
    send(8'hA5, 8'h3C, 4'b0001, 4'b0000, "g3/b5");
    txn_end("g3");

    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_mux_n.md
# spi_mux_n

Parametrised SPI mode-3 (CPOL=1, CPHA=1) multiplexer that routes one upstream SPI slave interface to one of NPORTS downstream devices, selected by an address byte at the start of each transaction. It sits between an external SPI master and a bank of SPI peripherals. Unlike the two-port mux, it drives an identification/status header back on MISO, supports a configurable turnaround length and an optional broadcast address, and holds idle ports' clocks high.

## Interface

- NPORTS, 4, number of downstream ports, 1..254
- GAP_BYTES, 1, turnaround bytes between address byte and pass-through, 1..4
- MUX_ID, 8'hA5, identification byte returned on MISO during the address byte
- s_sclk  input  1  clock; upstream SPI clock, idle high, sample on rising, setup on falling
- s_ss  input  1  reset; asynchronous, active-high (upstream select, active low: high = deselected = reset)
- s_mosi  input  1  upstream data in
- s_miso  output  1  upstream data out
- m_ss  output  [0:NPORTS-1]  per-port select, active low
- m_sclk  output  [0:NPORTS-1]  per-port clock, held high when port not active
- m_mosi  output  [0:NPORTS-1]  s_mosi fanned out to all ports
- m_miso  input  [0:NPORTS-1]  per-port data in

## Operation

- One clock (s_sclk, both edges), asynchronous active-high reset (s_ss). States: HDR_ADDR (rising-edge count 0..7), HDR_GAP (8..8*(1+GAP_BYTES)-1), PASS (count = HDR_LEN = 8*(1+GAP_BYTES), saturates).
- Reset values: rising-edge counter 0, shift register 0, address 0, all m_ss=1, all m_sclk=1, s_miso=0; m_mosi always = s_mosi.
- Address capture: 7-bit shift register samples s_mosi on rising edges 1..7 (MSB first); on rising edge 8 address <= {shift, s_mosi}. Address is held until reset.
- Decode: 0 = no port; 1..NPORTS = port addr-1; 8'hFF = broadcast (only with macro); anything else = no port (invalid).
- Echo byte: address if valid (including 8'hFF with broadcast enabled), else 8'hFF.
- s_miso during header, changed on falling edges only: before rising edge k (k = 0..7) drives MUX_ID[7-k]; during gap, before rising edge k drives echo[7-((k-8) mod 8)], repeated each gap byte.
- PASS: selected port(s) get m_ss=s_ss and m_sclk=s_sclk; all others m_ss=1, m_sclk=1. s_miso = m_miso of selected port; broadcast: AND of all m_miso; no port: 0.
- s_ss rising at any point: immediate async return to reset state; all downstream deselected in the same delta; partial address discarded.
- s_ss high: s_miso forced 0.

## Timing

- Address latched at rising edge 8; echo available from falling edge 8 (setup for rising edge 9).
- PASS entered at rising edge HDR_LEN (16 with defaults); m_ss of selected port falls combinationally after that edge while s_sclk is high, so the first downstream falling edge is the next upstream falling edge; no m_sclk glitch.
- Pass-through is combinational (s_sclk to m_sclk, m_miso to s_miso); zero added cycles.
- Counter width ceil(log2(HDR_LEN+1)); holds at HDR_LEN for arbitrarily long transfers (no wrap).

## Configuration

- SPI_MUX_BCAST_EN defined: address 8'hFF selects all ports simultaneously; MISO is AND of all m_miso; echo returns 8'hFF.
- Undefined: 8'hFF is invalid (no port selected, s_miso 0 in PASS, echo 8'hFF); no AND-reduction logic is generated.

## Test plan

- Defaults, send 8'h02 then 8'h00 then 8'hC3 with m_miso[1] tied to pattern 8'h5A -> s_miso bytes A5, 02, 5A; m_ss[1] low only during byte 3; m_sclk[1] toggles 8 times; other m_sclk stay 1.
- Send 8'h07 (NPORTS=4) plus 2 bytes -> echo 8'hFF; all m_ss=1, all m_sclk=1, s_miso 0 in byte 3.
- Send 8'h00 -> echo 8'h00, no port selected for the whole transaction.
- Raise s_ss after 5 rising edges of address 8'h01, then new transaction with 8'h03 -> port 2 selected, port 0 never selected.
- GAP_BYTES=3, address 8'h04 -> echo 8'h04 returned three times; m_ss[3] falls at rising edge 32.
- With SPI_MUX_BCAST_EN, address 8'hFF, m_miso = {1,0,1,1} -> all m_ss low in PASS, s_miso 0; without macro same stimulus -> no port selected.
